// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage feeding the IF/ID latch.
// Owns the program counter, drives icache reads and presents instr/pc/pc+4
// with a valid qualifier. Downstream stall, redirect and halt are applied here.
// Optional build macro IFETCH_PERF_EN adds fetch_count/squash_count outputs.
module ifetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pcplusfour_out,
  output logic        valid_out,
`ifdef IFETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count,
`endif
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_inc;
  logic        run;

  // Redirect targets are forced onto a word boundary; low bits are dropped
  // silently rather than trapping.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign run    = (state_q == ST_RUN);
  assign pc_inc = pc_q + PC_STEP;   // wraps naturally modulo 2^32

  assign imemaddr       = pc_q;
  assign pc_out         = pc_q;
  assign pcplusfour_out = pc_inc;
  assign instr_out      = imemload;
  assign imemREN        = run;
  assign halted         = (state_q == ST_HALTED);
  assign valid_out      = run & ihit & ~stall & ~redirect & ~halt;

  // Next-PC selection in priority order: halt, redirect, stall, hit, miss.
  always_comb begin
    pc_d = pc_q;
    if (run && !halt) begin
      if (redirect)
        pc_d = align_word(redirect_pc);
      else if (stall)
        pc_d = pc_q;
      else if (ihit)
        pc_d = pc_inc;
    end
  end

  // RUN/HALTED state machine and PC register; HALTED is left only via reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt)
            state_q <= ST_HALTED;
          pc_q <= pc_d;
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
          pc_q    <= pc_q;
        end
        default: begin
          state_q <= ST_RUN;
          pc_q    <= pc_q;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] squash_count_q;
  logic        squash_fire;

  // A squash is a hit that a same-cycle redirect throws away.
  assign squash_fire  = run & ihit & redirect & ~halt;
  assign fetch_count  = fetch_count_q;
  assign squash_count = squash_count_q;

  // Performance counters; both freeze in HALTED because they need run.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q  <= 32'd0;
      squash_count_q <= 32'd0;
    end else begin
      if (valid_out)
        fetch_count_q <= fetch_count_q + 32'd1;
      if (squash_fire)
        squash_count_q <= squash_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Testbench for ifetch_stage: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the fetch rules.
module tb_ifetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplusfour_out;
  logic        valid_out;
  logic        halted;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_halted;
  int unsigned m_fetches;
  int unsigned m_squashes;

  ifetch_stage dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .imemload       (imemload),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pcplusfour_out (pcplusfour_out),
    .valid_out      (valid_out),
`ifdef IFETCH_PERF_EN
    .fetch_count    (fetch_count),
    .squash_count   (squash_count),
`endif
    .halted         (halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_halted   = 0;
    m_fetches  = 0;
    m_squashes = 0;
  endtask

  task automatic check_perf();
`ifdef IFETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fetches);
    chk("squash_count", squash_count, m_squashes);
`endif
  endtask

  // Asynchronous reset taken mid-cycle; called just after a rising edge.
  task automatic do_reset();
    ihit = 0; stall = 0; redirect = 0; halt = 0;
    imemload = 32'h0; redirect_pc = 32'h0;
    nRST = 0;
    #2;
    model_reset();
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_imemREN", {31'b0, imemREN}, 32'h1);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    check_perf();
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
  endtask

  // One clock cycle: drive, check against model mid-cycle, advance model.
  task automatic step(input logic h, input logic [31:0] ld, input logic st,
                      input logic rd, input logic [31:0] rpc, input logic hl);
    bit exp_valid;
    bit exp_squash;
    ihit = h; imemload = ld; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
    @(negedge CLK);
    exp_valid  = !m_halted && h && !st && !rd && !hl;
    exp_squash = !m_halted && h && rd && !hl;
    chk("imemaddr", imemaddr, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("pcplusfour", pcplusfour_out, m_pc + 32'd4);
    chk("instr_out", instr_out, ld);
    chk("imemREN", {31'b0, imemREN}, {31'b0, !m_halted});
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
    check_perf();
    @(posedge CLK);
    #1;
    if (exp_valid)  m_fetches++;
    if (exp_squash) m_squashes++;
    if (!m_halted) begin
      if (hl)            m_halted = 1;
      else if (rd)       m_pc = (rpc / 4) * 4;
      else if (st)       ;
      else if (h)        m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic go(input logic [31:0] target);
    step(0, 32'h0, 0, 1, target, 0);
  endtask

  initial begin
    nRST = 0; ihit = 0; stall = 0; redirect = 0; halt = 0;
    imemload = 32'h0; redirect_pc = 32'h0;
    model_reset();
    #3;
    chk("init_imemaddr", imemaddr, 32'h0);
    chk("init_imemREN", {31'b0, imemREN}, 32'h1);
    chk("init_valid", {31'b0, valid_out}, 32'h0);
    chk("init_halted", {31'b0, halted}, 32'h0);
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;

    // sequential fetch
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imemaddr, 32'(i * 4));
      chk("seq_pc4", pcplusfour_out, 32'(i * 4 + 4));
      step(1, 32'hA000_0000 + 32'(i), 0, 0, 32'h0, 0);
    end
    step(1, 32'h1234_5678, 0, 0, 32'h0, 0);
    chk("at_0x10", imemaddr, 32'h10);

    // miss wait
    for (int i = 0; i < 4; i++) step(0, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    chk("miss_hold", imemaddr, 32'h10);
    step(1, 32'hCAFE_F00D, 0, 0, 32'h0, 0);
    chk("miss_resume", imemaddr, 32'h14);

    // stall with hit
    go(32'h20);
    step(1, 32'h1111_1111, 1, 0, 32'h0, 0);
    step(1, 32'h1111_1111, 1, 0, 32'h0, 0);
    chk("stall_hold", imemaddr, 32'h20);
    step(1, 32'h1111_1111, 0, 0, 32'h0, 0);
    chk("stall_release", imemaddr, 32'h24);

    // redirect beats stall and hit, target aligned
    go(32'h40);
    step(1, 32'h2222_2222, 1, 1, 32'h1003, 0);
    chk("redir_align", imemaddr, 32'h1000);

    // halt beats redirect
    go(32'h80);
    step(1, 32'h3333_3333, 0, 1, 32'h500, 1);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_ren", {31'b0, imemREN}, 32'h0);
    step(1, 32'h3333_3333, 0, 1, 32'h600, 0);
    step(1, 32'h3333_3333, 0, 0, 32'h0, 0);
    chk("halt_pc", imemaddr, 32'h80);
    do_reset();
    chk("post_halt_reset", imemaddr, 32'h0);

    // wrap-around
    go(32'hFFFF_FFFC);
    chk("wrap_pc4", pcplusfour_out, 32'h0);
    step(1, 32'h4444_4444, 0, 0, 32'h0, 0);
    chk("wrap_addr", imemaddr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) begin
        do_reset();
      end else begin
        step($urandom_range(99) < 65, $urandom,
             $urandom_range(99) < 20, $urandom_range(99) < 15,
             $urandom, $urandom_range(99) < 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
